// File: rtl/dmem_pkg.sv
// Shared types and defaults for the dmem_responder slice: FSM states and the
// captured request record.
package dmem_pkg;

  localparam int DMEM_DEPTH_DEFAULT   = 64;
  localparam int DMEM_LATENCY_DEFAULT = 2;
  // Widest possible word index for a 32-bit byte address
  localparam int DMEM_MAX_IDX_W       = 30;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic                      write;
    logic [DMEM_MAX_IDX_W-1:0] idx;
    logic [31:0]               wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_resp_array.sv
// DEPTH x 32 word storage: synchronous clear on reset, one write port and a
// registered read-on-enable output with its own clear.
module dmem_resp_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (rd_clr) begin
        rdata <= '0;
      end else if (rd_en) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked single-outstanding memory slave with fixed access latency.
// Define DMEM_RESP_ERR_EN to flag misaligned / out-of-range requests via resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY = DMEM_LATENCY_DEFAULT,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t req_q, req_d;
  logic err_q, err_d;
  logic addr_err;
  logic arr_we, arr_rd_en, arr_rd_clr;

`ifdef DMEM_RESP_ERR_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);
  assign resp_err = (state_q == RESP) && err_q;
`else
  // Unused address bits alias modulo DEPTH
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:IDX_W+2]};
  assign addr_err = 1'b0;
  assign resp_err = 1'b0;
`endif

  logic unused_idx_bits;
  assign unused_idx_bits = ^req_q.idx[DMEM_MAX_IDX_W-1:IDX_W];

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    err_d      = err_q;
    arr_we     = 1'b0;
    arr_rd_en  = 1'b0;
    arr_rd_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d.write = req_write;
          req_d.idx   = DMEM_MAX_IDX_W'(req_addr[IDX_W+1:2]);
          req_d.wdata = req_wdata;
          err_d       = addr_err;
          cnt_d       = CNT_W'(LATENCY - 1);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Storage is only touched at the response edge; errors never write
          arr_we     = req_q.write && !err_q;
          arr_rd_en  = !req_q.write && !err_q;
          arr_rd_clr = req_q.write || err_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          arr_rd_clr = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  dmem_resp_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .rd_en (arr_rd_en),
    .rd_clr(arr_rd_clr),
    .addr  (req_q.idx[IDX_W-1:0]),
    .wdata (req_q.wdata),
    .rdata (resp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a word-array
// reference model; honours DMEM_RESP_ERR_EN when defined.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int IDX_W = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
    return (a % 4 != 0) || ((a >> (IDX_W + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then presents the request; returns at #1
  // after the acceptance edge with junk on the request inputs.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("req_ready_timeout", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int stall);
    logic        e;
    logic [31:0] exp_rd;
    int          idx;
    e      = model_err(a);
    idx    = model_idx(a);
    exp_rd = (wr || e) ? 32'h0 : model_mem[idx];
    issue(wr, a, d);
    for (int k = 1; k <= LAT; k++) begin
      chk("busy_resp_valid", resp_valid, 1'b0);
      chk("busy_req_ready", req_ready, 1'b0);
      req_valid  = 1'($urandom);
      resp_ready = 1'($urandom);
      step();
    end
    if (wr && !e) model_mem[idx] = d;
    chk("resp_valid_at_latency", resp_valid, 1'b1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", resp_err, e);
    for (int s = 0; s < stall; s++) begin
      resp_ready = 1'b0;
      req_valid  = 1'($urandom);
      step();
      chk("stall_resp_valid", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("post_resp_valid", resp_valid, 1'b0);
    chk("post_rdata", resp_rdata, 32'h0);
    chk("post_err", resp_err, 1'b0);
    chk("post_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    clear_model();
    step();
    step();
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_rdata", resp_rdata, 32'h0);
    chk("reset_err", resp_err, 1'b0);
    reset = 1'b0;
    step();
    chk("first_req_ready", req_ready, 1'b1);

    // resp_ready with nothing pending is ignored
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("idle_resp_ready_ignored", resp_valid, 1'b0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    chk("wr_rd_model", model_mem[4], 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0, 5);

    txn(1'b1, 32'h104, 32'h11111111, 1);
    txn(1'b0, 32'h004, 32'h0, 0);

    // Reset while BUSY abandons the write and clears storage
    issue(1'b1, 32'h20, 32'hCAFEF00D);
    reset = 1'b1;
    step();
    chk("midreset_resp_valid", resp_valid, 1'b0);
    chk("midreset_req_ready", req_ready, 1'b0);
    step();
    chk("midreset_resp_valid2", resp_valid, 1'b0);
    reset = 1'b0;
    clear_model();
    step();
    chk("midreset_ready_after", req_ready, 1'b1);
    txn(1'b0, 32'h20, 32'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 0);

    txn(1'b0, 32'h102, 32'h0, 0);
    txn(1'b1, 32'h400, 32'h5, 0);
    txn(1'b0, 32'h000, 32'h0, 2);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
